// File: rtl/dds_phase_gen.sv
// -----------------------------------------------------------------------------
// dds_phase_gen
//   Phase-accumulator address generator for the DDS datapath. Steps a phase
//   accumulator by the tuning word, drives the waveform ROM address (top bits
//   of the accumulator plus a phase offset) and retimes the returned ROM word
//   into a validated sample stream. While running, a new tuning word / phase
//   offset is held in shadow registers and takes effect at the next accumulator
//   wrap, so frequency changes stay phase-continuous.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   en_i          run enable
//   cfg_valid_i   configuration offer
//   cfg_ready_o   configuration accept (low while an update is pending)
//   ftw_i         frequency tuning word
//   pow_i         phase offset in ROM-address units
//   rom_addr_o    registered ROM address
//   rom_q_i       ROM data, one-cycle registered read latency
//   dout_o        output sample (rom_q_i retimed)
//   dout_valid_o  dout_o carries a sample whose address came from an enabled step
//   wrap_o        one-cycle pulse aligned with the rom_addr_o of a wrapping step
//
// Build option
//   DDS_DITHER_EN  adds a 16-bit LFSR whose low bits are added below the
//                  truncation point of the ROM address (address only; the
//                  accumulator, carry and wrap are unaffected).
//
// States
//   S_IDLE | disabled; a handshake writes the active config directly
//   S_RUN  | enabled, no update pending; a handshake fills the shadow
//   S_PEND | shadow holds an update waiting for the next wrap step
// -----------------------------------------------------------------------------
module dds_phase_gen #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [PHASE_WIDTH-1:0] ftw_i,
  input  logic [ADDR_WIDTH-1:0]  pow_i,
  output logic [ADDR_WIDTH-1:0]  rom_addr_o,
  input  logic [DATA_WIDTH-1:0]  rom_q_i,
  output logic [DATA_WIDTH-1:0]  dout_o,
  output logic                   dout_valid_o,
  output logic                   wrap_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] ftw_q, ftw_d;
  logic [PHASE_WIDTH-1:0] ftw_s_q, ftw_s_d;
  logic [ADDR_WIDTH-1:0]  pow_q, pow_d;
  logic [ADDR_WIDTH-1:0]  pow_s_q, pow_s_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wrap_q, wrap_d;
  logic                   v1_q, v2_q, dout_valid_q;
  logic [DATA_WIDTH-1:0]  dout_q;

  logic [PHASE_WIDTH:0]   sum;
  logic [PHASE_WIDTH-1:0] acc_next;
  logic                   carry;
  logic [ADDR_WIDTH-1:0]  addr_top;
  logic                   handshake;

  assign sum      = {1'b0, acc_q} + {1'b0, ftw_q};
  assign acc_next = sum[PHASE_WIDTH-1:0];
  assign carry    = sum[PHASE_WIDTH];

`ifdef DDS_DITHER_EN
  localparam int DITHER_W = ((PHASE_WIDTH - ADDR_WIDTH) < 16) ? (PHASE_WIDTH - ADDR_WIDTH) : 16;

  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = en_i ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;

  // Dither sits below the truncation point; it only perturbs the address.
  assign addr_top = ADDR_WIDTH'((acc_next + PHASE_WIDTH'(lfsr_q[DITHER_W-1:0]))
                                >> (PHASE_WIDTH - ADDR_WIDTH));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign addr_top = ADDR_WIDTH'(acc_next >> (PHASE_WIDTH - ADDR_WIDTH));
`endif

  assign cfg_ready_o = (state_q != S_PEND);
  assign handshake   = cfg_valid_i & cfg_ready_o;

  always_comb begin
    state_d = state_q;
    ftw_d   = ftw_q;
    pow_d   = pow_q;
    ftw_s_d = ftw_s_q;
    pow_s_d = pow_s_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    wrap_d  = 1'b0;

    if (en_i) begin
      acc_d  = acc_next;
      addr_d = addr_top + pow_q;
      wrap_d = carry;
    end

    case (state_q)
      S_IDLE, S_RUN: begin
        state_d = en_i ? S_RUN : S_IDLE;
        if (handshake) begin
          // Only a running accumulator must wait for a wrap; otherwise
          // the new config can go straight into the active registers.
          if (state_q == S_RUN && en_i) begin
            ftw_s_d = ftw_i;
            pow_s_d = pow_i;
            state_d = S_PEND;
          end else begin
            ftw_d = ftw_i;
            pow_d = pow_i;
          end
        end
      end
      S_PEND: begin
        if (!en_i) begin
          ftw_d   = ftw_s_q;
          pow_d   = pow_s_q;
          state_d = S_IDLE;
        end else if (carry) begin
          ftw_d   = ftw_s_q;
          pow_d   = pow_s_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      ftw_q        <= '0;
      pow_q        <= '0;
      ftw_s_q      <= '0;
      pow_s_q      <= '0;
      addr_q       <= '0;
      wrap_q       <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
      pow_q        <= pow_d;
      ftw_s_q      <= ftw_s_d;
      pow_s_q      <= pow_s_d;
      addr_q       <= addr_d;
      wrap_q       <= wrap_d;
      // Valid follows the address through the ROM read and the output register.
      v1_q         <= en_i;
      v2_q         <= v1_q;
      dout_valid_q <= v2_q;
      dout_q       <= rom_q_i;
    end
  end

  assign rom_addr_o   = addr_q;
  assign wrap_o       = wrap_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] ftw = '0;
  logic [7:0]  pow = '0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_q = '0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        wrap;

  always #5 clk = ~clk;

  dds_phase_gen #(.PHASE_WIDTH(32), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready), .ftw_i(ftw), .pow_i(pow), .rom_addr_o(rom_addr),
    .rom_q_i(rom_q), .dout_o(dout), .dout_valid_o(dout_valid), .wrap_o(wrap)
  );

  logic [7:0] rom [256];
  always @(posedge clk) rom_q <= rom[rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the generator, advanced once per clock edge.
  logic [31:0] m_acc, m_ftw, m_ftw_s;
  logic [7:0]  m_pow, m_pow_s, m_addr;
  logic [15:0] m_lfsr;
  int          m_state;  // 0 idle, 1 run, 2 pending

  typedef struct {logic [7:0] addr; logic en;} samp_t;
  samp_t sb[$];

  task automatic model_reset();
    m_acc = '0; m_ftw = '0; m_ftw_s = '0; m_pow = '0; m_pow_s = '0;
    m_addr = '0; m_lfsr = 16'hACE1; m_state = 0;
    sb.delete();
    // The two pipeline stages behind rom_addr are empty right after reset.
    sb.push_back('{addr: 8'h00, en: 1'b0});
    sb.push_back('{addr: 8'h00, en: 1'b0});
  endtask

  // Drive one clock edge with the current inputs and check the results.
  task automatic step();
    logic [32:0] s;
    logic [31:0] src;
    logic        carry;
    logic        hs;
    logic        exp_wrap;
    samp_t       e;
    chk("cfg_ready", cfg_ready, (m_state != 2));
    hs = cfg_valid && (m_state != 2);
    carry = 1'b0;
    exp_wrap = 1'b0;
    if (en) begin
      s = {1'b0, m_acc} + {1'b0, m_ftw};
      carry = s[32];
      src = s[31:0];
`ifdef DDS_DITHER_EN
      src = src + {16'h0000, m_lfsr};
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
      m_addr = src[31:24] + m_pow;
      m_acc = s[31:0];
      exp_wrap = carry;
    end
    case (m_state)
      0, 1: begin
        if (hs && m_state == 1 && en) begin
          m_ftw_s = ftw; m_pow_s = pow; m_state = 2;
        end else begin
          if (hs) begin m_ftw = ftw; m_pow = pow; end
          m_state = en ? 1 : 0;
        end
      end
      default: begin
        if (!en) begin
          m_ftw = m_ftw_s; m_pow = m_pow_s; m_state = 0;
        end else if (carry) begin
          m_ftw = m_ftw_s; m_pow = m_pow_s; m_state = 1;
        end
      end
    endcase
    sb.push_back('{addr: m_addr, en: en});
    @(posedge clk);
    #1;
    chk("rom_addr", rom_addr, m_addr);
    chk("wrap", wrap, exp_wrap);
    if (sb.size() > 2) begin
      e = sb.pop_front();
      chk("dout_valid", dout_valid, e.en);
      if (e.en) chk("dout", dout, rom[e.addr]);
    end
  endtask

  // Called 1 time unit after a clock edge; reset takes effect without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [7:0] held;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) & 255);
    #1;
    do_reset();

    // Load FTW in IDLE, then run: addresses 1,2,...,255,0 with wrap on 255->0.
    cfg_valid = 1'b1; ftw = 32'h0100_0000; pow = 8'h00;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    step();
    chk("first_addr", rom_addr, 8'h01);
    repeat (254) step();
    chk("addr_255", rom_addr, 8'hFF);
    chk("no_wrap_255", wrap, 1'b0);
    step();
    chk("addr_wrap_0", rom_addr, 8'h00);
    chk("wrap_255_0", wrap, 1'b1);
    repeat (300) step();

    // Phase offset loaded in IDLE.
    en = 1'b0;
    cfg_valid = 1'b1; ftw = 32'h0100_0000; pow = 8'h40;
    step();
    held = m_acc[31:24];
    cfg_valid = 1'b0; en = 1'b1;
    step();
    chk("pow_offset", rom_addr, 8'(held + 8'h41));
    repeat (300) step();

    // Mid-period update while running.
    for (int i = 0; i < 300 && m_acc[31:24] != 8'd100; i++) step();
    cfg_valid = 1'b1; ftw = 32'h0200_0000; pow = 8'h40;
    step();
    cfg_valid = 1'b0;
    chk("ready_drop", cfg_ready, 1'b0);
    for (int i = 0; i < 300 && !wrap; i++) step();
    chk("mid_wrap_seen", wrap, 1'b1);
    chk("ready_back", cfg_ready, 1'b1);
    step();
    chk("step2_after_wrap", rom_addr, 8'h42);
    repeat (200) step();

    // Update offered on the same edge as a wrap step.
    for (int i = 0; i < 300 && ({1'b0, m_acc} + {1'b0, m_ftw}) < 33'h1_0000_0000; i++) step();
    cfg_valid = 1'b1; ftw = 32'h0100_0000; pow = 8'h40;
    step();
    cfg_valid = 1'b0;
    chk("coinc_wrap", wrap, 1'b1);
    chk("coinc_pend", cfg_ready, 1'b0);
    repeat (127) step();
    chk("coinc_old_ftw", rom_addr, 8'h3E);
    step();
    chk("coinc_second_wrap", wrap, 1'b1);
    chk("coinc_ready", cfg_ready, 1'b1);
    step();
    chk("coinc_new_ftw", rom_addr, 8'h41);
    repeat (20) step();

    // Enable low for five cycles.
    held = m_addr;
    en = 1'b0;
    repeat (5) step();
    chk("en_low_hold", rom_addr, held);
    en = 1'b1;
    step();
    chk("en_resume", rom_addr, 8'(held + 8'h01));
    repeat (20) step();

    // Enable falling while an update is pending applies it.
    cfg_valid = 1'b1; ftw = 32'h0300_0000; pow = 8'h40;
    step();
    cfg_valid = 1'b0; en = 1'b0;
    step();
    held = m_addr;
    chk("pend_to_idle_ready", cfg_ready, 1'b1);
    en = 1'b1;
    step();
    chk("pend_en_fall", rom_addr, 8'(held + 8'h03));
    repeat (20) step();

    // Reset while pending discards the update.
    cfg_valid = 1'b1; ftw = 32'h0200_0000; pow = 8'h10;
    step();
    cfg_valid = 1'b0;
    chk("pend_before_rst", cfg_ready, 1'b0);
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ftw0_frozen", rom_addr, 8'h00);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      ftw = $urandom();
      pow = 8'($urandom_range(0, 255));
      step();
    end
    cfg_valid = 1'b0;

`ifdef DDS_DITHER_EN
    en = 1'b0;
    do_reset();
    cfg_valid = 1'b1; ftw = 32'h0080_0000; pow = 8'h00;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    repeat (300) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
